// File: rtl/bsg_fifo_rolly_replay_ctrl.sv
// Read-side replay sequencer for a rolly FIFO feeding a lossy link: streams words, commits on ack, rolls back on nack.
// Optional auto-rollback on an idle timeout when BSG_ROLLY_REPLAY_TIMEOUT_EN is defined.
module bsg_fifo_rolly_replay_ctrl #(
    parameter int width_p       = 8,
    parameter int window_p      = 8,
    parameter int max_retries_p = 3,
    parameter int timeout_p     = 64
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 fifo_v_i,
    input  logic [width_p-1:0]                   fifo_data_i,
    output logic                                 fifo_yumi_o,
    output logic                                 fifo_rollback_o,
    output logic                                 fifo_ack_o,
    output logic                                 link_v_o,
    output logic [width_p-1:0]                   link_data_o,
    input  logic                                 link_ready_i,
    input  logic                                 link_ack_i,
    input  logic                                 link_nack_i,
    output logic [$clog2(window_p+1)-1:0]        outstanding_o,
    output logic [$clog2(max_retries_p+1)-1:0]   retry_cnt_o,
    output logic                                 error_o
);
    localparam int ow_lp = $clog2(window_p+1);
    localparam int rw_lp = $clog2(max_retries_p+1);
    localparam logic [ow_lp-1:0] window_lp      = ow_lp'(window_p);
    localparam logic [rw_lp:0]   max_retries_lp = (rw_lp+1)'(max_retries_p);

    // state  | meaning
    // SEND   | stream words while the window has room
    // WAIT   | window full, waiting for ack/nack/timeout
    // ROLLBK | one-cycle FIFO rollback strobe
    // ERROR  | retry limit exceeded, absorbing until reset
    typedef enum logic [1:0] {e_send, e_wait, e_rollbk, e_error} state_e;

    state_e            state_r, state_n;
    logic [ow_lp-1:0]  out_r, out_n;
    logic [rw_lp-1:0]  retry_r, retry_n;
    logic [rw_lp:0]    retry_inc;
    logic              active, fail, timeout;
    logic              link_v, yumi, ack, rollback, err;

    assign active    = (state_r == e_send) || (state_r == e_wait);
    assign fail      = (link_nack_i | timeout) & (out_r != '0);
    assign retry_inc = {1'b0, retry_r} + (rw_lp+1)'(1);

`ifdef BSG_ROLLY_REPLAY_TIMEOUT_EN
    localparam int tw_lp = $clog2(timeout_p);
    localparam logic [tw_lp-1:0] timer_load_lp = tw_lp'(timeout_p - 1);

    logic [tw_lp-1:0] timer_r;
    logic             idle;

    // Down-counter reloads whenever the link shows progress; terminal count acts as a nack.
    assign idle    = active & (out_r != '0) & ~link_ack_i & ~yumi;
    assign timeout = active & (out_r != '0) & (timer_r == '0);

    always_ff @(posedge clk_i) begin
        if (reset_i || !idle)
            timer_r <= timer_load_lp;
        else if (timer_r != '0)
            timer_r <= timer_r - tw_lp'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n  = state_r;
        out_n    = out_r;
        retry_n  = retry_r;
        link_v   = 1'b0;
        yumi     = 1'b0;
        ack      = 1'b0;
        rollback = 1'b0;
        err      = 1'b0;
        case (state_r)
            e_send, e_wait: begin
                // A pending rollback blocks new sends unless an ack overrides it.
                if (state_r == e_send && (link_ack_i || !fail)) begin
                    link_v = fifo_v_i & (out_r < window_lp);
                    yumi   = link_v & link_ready_i;
                end
                if (link_ack_i) begin
                    ack     = 1'b1;
                    out_n   = yumi ? ow_lp'(1) : '0;
                    retry_n = '0;
                end else if (yumi) begin
                    out_n = out_r + ow_lp'(1);
                end
                if (!link_ack_i && fail)
                    state_n = e_rollbk;
                else
                    state_n = (out_n == window_lp) ? e_wait : e_send;
            end
            e_rollbk: begin
                rollback = 1'b1;
                out_n    = '0;
                if (retry_inc > max_retries_lp) begin
                    state_n = e_error;
                end else begin
                    retry_n = retry_inc[rw_lp-1:0];
                    state_n = e_send;
                end
            end
            e_error: err = 1'b1;
            default: state_n = e_send;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_send;
            out_r   <= '0;
            retry_r <= '0;
        end else begin
            state_r <= state_n;
            out_r   <= out_n;
            retry_r <= retry_n;
        end
    end

    assign link_v_o        = link_v & ~reset_i;
    assign fifo_yumi_o     = yumi & ~reset_i;
    assign fifo_ack_o      = ack & ~reset_i;
    assign fifo_rollback_o = rollback & ~reset_i;
    assign error_o         = err & ~reset_i;
    assign link_data_o     = fifo_data_i;
    assign outstanding_o   = out_r;
    assign retry_cnt_o     = retry_r;

    assert property (@(posedge clk_i) disable iff (reset_i) !(fifo_ack_o && fifo_rollback_o));
    assert property (@(posedge clk_i) disable iff (reset_i) out_r <= window_lp);
    assert property (@(posedge clk_i) (window_p >= 1) && (max_retries_p >= 1) && (timeout_p >= 2));

endmodule

// File: tb/tb_bsg_fifo_rolly_replay_ctrl.sv
// Directed bench for bsg_fifo_rolly_replay_ctrl with a behavioural rolly FIFO and a window/retry model.
module tb_bsg_fifo_rolly_replay_ctrl;
    localparam int WID  = 8;
    localparam int WIN  = 4;
    localparam int MAXR = 3;
    localparam int TMO  = 16;
`ifdef BSG_ROLLY_REPLAY_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           fifo_v;
    logic [WID-1:0] fifo_data;
    logic           fifo_yumi, fifo_rollback, fifo_ack;
    logic           link_v;
    logic [WID-1:0] link_data;
    logic           link_ready, link_ack, link_nack;
    logic [2:0]     outstanding;
    logic [1:0]     retry_cnt;
    logic           error;

    bsg_fifo_rolly_replay_ctrl #(
        .width_p(WID), .window_p(WIN), .max_retries_p(MAXR), .timeout_p(TMO)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .fifo_v_i(fifo_v), .fifo_data_i(fifo_data),
        .fifo_yumi_o(fifo_yumi), .fifo_rollback_o(fifo_rollback), .fifo_ack_o(fifo_ack),
        .link_v_o(link_v), .link_data_o(link_data), .link_ready_i(link_ready),
        .link_ack_i(link_ack), .link_nack_i(link_nack),
        .outstanding_o(outstanding), .retry_cnt_o(retry_cnt), .error_o(error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [WID-1:0] word(input int i);
        return WID'(8'hA0 + i);
    endfunction

    // Rolly FIFO: read pointer, commit pointer, write count set by the stimulus.
    int rd = 0, cmt = 0, wr = 0;
    int sent_cnt = 0, rb_cnt = 0;
    assign fifo_v    = (rd < wr);
    assign fifo_data = word(rd);

    always @(posedge clk) begin
        if (reset) begin
            rd  <= 0;
            cmt <= 0;
        end else if (fifo_rollback) begin
            rd <= cmt;
        end else begin
            if (fifo_yumi) rd <= rd + 1;
            if (fifo_ack)  cmt <= rd;
        end
        if (!reset) begin
            if (fifo_yumi)     sent_cnt <= sent_cnt + 1;
            if (fifo_rollback) rb_cnt   <= rb_cnt + 1;
        end
    end

    // Model: words outstanding, index of first uncommitted word, retries, idle cycles.
    int m_out = 0, m_cmt = 0, m_retry = 0, m_idle = 0;
    bit m_rb = 0, m_err = 0;
    bit e_v, e_yumi, e_ack, e_rb, e_err, e_fail, e_tmo;
    bit started = 0;

    always_comb begin
        e_v = 0; e_yumi = 0; e_ack = 0; e_rb = 0; e_err = 0; e_fail = 0; e_tmo = 0;
        if (reset) begin
            e_v = 0;
        end else if (m_err) begin
            e_err = 1;
        end else if (m_rb) begin
            e_rb = 1;
        end else begin
            e_tmo  = TMO_EN && (m_out > 0) && (m_idle >= TMO - 1);
            e_fail = (link_nack || e_tmo) && (m_out > 0);
            e_ack  = link_ack;
            e_v    = (link_ack || !e_fail) && fifo_v && (m_out < WIN);
            e_yumi = e_v && link_ready;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            m_out <= 0; m_cmt <= 0; m_retry <= 0; m_idle <= 0; m_rb <= 0; m_err <= 0;
        end else if (m_err) begin
            m_idle <= 0;
        end else if (m_rb) begin
            m_rb   <= 0;
            m_out  <= 0;
            m_idle <= 0;
            if (m_retry + 1 > MAXR) m_err <= 1;
            else                    m_retry <= m_retry + 1;
        end else if (link_ack) begin
            m_cmt   <= m_cmt + m_out;
            m_out   <= e_yumi ? 1 : 0;
            m_retry <= 0;
            m_idle  <= 0;
        end else if (e_fail) begin
            m_rb   <= 1;
            m_idle <= 0;
        end else if (e_yumi) begin
            m_out  <= m_out + 1;
            m_idle <= 0;
        end else begin
            m_idle <= (m_out > 0) ? m_idle + 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("link_v", link_v, e_v);
            chk("yumi", fifo_yumi, e_yumi);
            chk("fifo_ack", fifo_ack, e_ack);
            chk("rollback", fifo_rollback, e_rb);
            chk("error", error, e_err);
            chk("outstanding", outstanding, m_out);
            chk("retry_cnt", retry_cnt, m_retry);
            if (e_v) chk("link_data", link_data, word(m_cmt + m_out));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int i;
    int rb0;

    initial begin
        reset = 1; link_ack = 0; link_nack = 0; link_ready = 1; wr = 0;
        step();
        started = 1;
        step();
        reset = 0; #1;
        chk("rst_out", outstanding, 0);
        chk("rst_retry", retry_cnt, 0);
        chk("rst_err", error, 0);
        chk("rst_linkv", link_v, 0);

        // Fill the window: 4 sends then WAIT.
        wr = 10;
        repeat (6) step();
        #1;
        chk("t1_out", outstanding, 4);
        chk("t1_linkv", link_v, 0);
        chk("t1_sent", sent_cnt, 4);

        // Ack commits and the next four words flow.
        link_ack = 1; #1;
        chk("t2_ack", fifo_ack, 1);
        chk("t2_linkv", link_v, 0);
        step();
        link_ack = 0;
        repeat (5) step();
        #1;
        chk("t2_out", outstanding, 4);
        chk("t2_sent", sent_cnt, 8);

        // Ack in the same cycle as a send keeps that word outstanding.
        link_ack = 1;
        step();
        #1;
        chk("t3_yumi", fifo_yumi, 1);
        chk("t3_ack", fifo_ack, 1);
        chk("t3_data", link_data, 'hA8);
        step();
        link_ack = 0; #1;
        chk("t3_out", outstanding, 1);
        step();

        // Three outstanding (8,9,10), nack, replay from word 8.
        wr = 20;
        step();
        link_nack = 1; link_ready = 1; #1;
        chk("t4_yumi_sup", fifo_yumi, 0);
        step();
        link_nack = 0; link_ready = 0; #1;
        chk("t4_rb", fifo_rollback, 1);
        step();
        #1;
        chk("t4_retry", retry_cnt, 1);
        chk("t4_out", outstanding, 0);
        link_ready = 1; #1;
        chk("t4_replay", link_data, 'hA8);
        chk("t4_yumi", fifo_yumi, 1);
        repeat (4) step();

        // Ack and nack together: ack wins, retries clear.
        link_ack = 1; link_nack = 1; #1;
        chk("an_ack", fifo_ack, 1);
        step();
        link_ack = 0; link_nack = 0; link_ready = 0; #1;
        chk("an_rb", fifo_rollback, 0);
        chk("an_retry", retry_cnt, 0);
        chk("an_out", outstanding, 0);

        // Nack with nothing outstanding is ignored.
        link_nack = 1;
        step();
        link_nack = 0; #1;
        chk("n0_rb", fifo_rollback, 0);

        // Four consecutive failed replays reach the error state.
        for (int k = 0; k < 4; k++) begin
            link_ready = 1;
            step();
            link_ready = 0; link_nack = 1;
            step();
            link_nack = 0; #1;
            chk("t5_rb", fifo_rollback, 1);
            step();
            #1;
            if (k < 3) chk("t5_retry", retry_cnt, k + 1);
        end
        chk("t5_err", error, 1);
        chk("t5_retry_sat", retry_cnt, 3);
        link_ready = 1; link_ack = 1; #1;
        chk("t5_linkv", link_v, 0);
        chk("t5_ack", fifo_ack, 0);
        repeat (4) step();
        #1;
        chk("t5_err_hold", error, 1);

        // Reset from the error state: no strobes while reset is high.
        reset = 1; wr = 0; #1;
        chk("rst2_ack", fifo_ack, 0);
        chk("rst2_rb", fifo_rollback, 0);
        step();
        reset = 0; link_ack = 0; #1;
        chk("rst2_err", error, 0);
        chk("rst2_out", outstanding, 0);
        chk("rst2_retry", retry_cnt, 0);

        // Two words sent, then the link goes quiet.
        wr = 2; link_ready = 1;
        step();
        step();
        rb0 = rb_cnt;
`ifdef BSG_ROLLY_REPLAY_TIMEOUT_EN
        i = 0; #1;
        while (!fifo_rollback && i < 40) begin
            step();
            #1;
            i++;
        end
        chk("t6_tmo_cycles", i, 16);
        step();
        #1;
        chk("t6_out", outstanding, 0);
        chk("t6_retry", retry_cnt, 1);
`else
        repeat (40) step();
        #1;
        chk("t6_no_tmo_out", outstanding, 2);
        chk("t6_no_tmo_rb", rb_cnt - rb0, 0);
`endif
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
